// File: rtl/pe_mac_sys.sv
// pe_mac_sys: systolic processing element with a signed multiply-accumulate.
//
// Two-stage pipeline: stage 1 registers the full-width signed product, stage 2
// either accumulates it internally (output-stationary) or adds it to the
// incoming partial sum (weight-stationary). Operands are forwarded to the
// neighbouring PEs through a one-cycle register.
//
// Parameters
//   DATA_W  operand width (signed)
//   ACC_W   accumulator / partial-sum width, must be >= 2*DATA_W
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clr_i                  synchronous accumulator clear (clear-then-add)
//   we_i, mode_i           start one MAC; mode 0 = OS, 1 = WS (sampled with we_i)
//   wload_i                load weight register from srcb_i
//   srca_i, srcb_i         activation / weight operands
//   psum_i                 incoming partial sum (WS)
//   srca_o, srcb_o         forwarded operands, fwd_vld_o marks them valid
//   psum_o, valid_o        result (OS accumulator or WS sum) and its strobe
//   ovf_o                  sticky saturation flag (only with PE_SAT_EN)
//
// Build option
//   PE_SAT_EN  stage-2 sums saturate to the signed ACC_W range and ovf_o is
//              present; when undefined, sums wrap modulo 2^ACC_W.

module pe_mac_sys #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic              mode_i,
    input  logic              wload_i,
    input  logic [DATA_W-1:0] srca_i,
    input  logic [DATA_W-1:0] srcb_i,
    input  logic [ACC_W-1:0]  psum_i,
    output logic [DATA_W-1:0] srca_o,
    output logic [DATA_W-1:0] srcb_o,
    output logic              fwd_vld_o,
    output logic [ACC_W-1:0]  psum_o,
    output logic              valid_o
`ifdef PE_SAT_EN
    ,
    output logic              ovf_o
`endif
);

    localparam int unsigned PROD_W = 2 * DATA_W;

`ifdef PE_SAT_EN
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Forwarding registers
    logic [DATA_W-1:0] srca_q, srca_d;
    logic [DATA_W-1:0] srcb_q, srcb_d;
    logic              fwd_vld_q, fwd_vld_d;

    // Weight register
    logic [DATA_W-1:0] w_q, w_d;

    // Stage 1 registers
    logic signed [PROD_W-1:0] p_q, p_d;
    logic [ACC_W-1:0]         psum_q, psum_d;
    logic                     mode_q, mode_d;
    logic                     v1_q, v1_d;

    // Stage 2 / result registers
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic             res_mode_q, res_mode_d;
    logic             valid_q, valid_d;
    logic [ACC_W-1:0] res_q, res_d;

`ifdef PE_SAT_EN
    logic             ovf_q, ovf_d;
    logic signed [SUM_W-1:0] sum_c;
    logic             sat_hit_c;
`endif

    logic [DATA_W-1:0]       opb_c;
    logic signed [ACC_W-1:0] p_ext_c;
    logic [ACC_W-1:0]        acc_base_c;
    logic signed [ACC_W-1:0] add_a_c;
    logic [ACC_W-1:0]        sum_res_c;

    // Operand forwarding and weight load
    always_comb begin
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        fwd_vld_d = 1'b0;
        w_d       = w_q;
        if (we_i || wload_i) begin
            srca_d    = srca_i;
            srcb_d    = srcb_i;
            fwd_vld_d = 1'b1;
        end
        if (wload_i) begin
            w_d = srcb_i;
        end
    end

    // Stage 1: product; a weight loaded this cycle is not yet visible via w_q
    always_comb begin
        opb_c  = mode_i ? w_q : srcb_i;
        p_d    = p_q;
        psum_d = psum_q;
        mode_d = mode_q;
        v1_d   = 1'b0;
        if (we_i) begin
            p_d    = PROD_W'($signed(srca_i)) * PROD_W'($signed(opb_c));
            psum_d = psum_i;
            mode_d = mode_i;
            v1_d   = 1'b1;
        end
    end

    // Stage 2 adder: clear is applied to the accumulator before the add
    always_comb begin
        p_ext_c    = ACC_W'(p_q);
        acc_base_c = clr_i ? '0 : acc_q;
        add_a_c    = mode_q ? psum_q : acc_base_c;
`ifdef PE_SAT_EN
        sum_c     = SUM_W'(add_a_c) + SUM_W'(p_ext_c);
        sat_hit_c = sum_c[SUM_W-1] ^ sum_c[SUM_W-2];
        if (sat_hit_c) begin
            sum_res_c = sum_c[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_res_c = sum_c[ACC_W-1:0];
        end
`else
        sum_res_c = add_a_c + p_ext_c;
`endif
    end

    // Stage 2 result update and output select
    always_comb begin
        acc_d      = acc_base_c;
        out_d      = out_q;
        res_mode_d = res_mode_q;
        valid_d    = 1'b0;
        if (v1_q) begin
            valid_d    = 1'b1;
            res_mode_d = mode_q;
            if (mode_q) begin
                out_d = sum_res_c;
            end else begin
                acc_d = sum_res_c;
            end
        end
        // Registered copy of the mode-selected result keeps psum_o glitch-free
        res_d = res_mode_d ? out_d : acc_d;
`ifdef PE_SAT_EN
        ovf_d = (clr_i ? 1'b0 : ovf_q) | (v1_q & sat_hit_c);
`endif
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            srca_q     <= '0;
            srcb_q     <= '0;
            fwd_vld_q  <= 1'b0;
            w_q        <= '0;
            p_q        <= '0;
            psum_q     <= '0;
            mode_q     <= 1'b0;
            v1_q       <= 1'b0;
            acc_q      <= '0;
            out_q      <= '0;
            res_mode_q <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
`ifdef PE_SAT_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            fwd_vld_q  <= fwd_vld_d;
            w_q        <= w_d;
            p_q        <= p_d;
            psum_q     <= psum_d;
            mode_q     <= mode_d;
            v1_q       <= v1_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            res_mode_q <= res_mode_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
`ifdef PE_SAT_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign srca_o    = srca_q;
    assign srcb_o    = srcb_q;
    assign fwd_vld_o = fwd_vld_q;
    assign psum_o    = res_q;
    assign valid_o   = valid_q;
`ifdef PE_SAT_EN
    assign ovf_o     = ovf_q;
`endif

endmodule

// File: tb/tb_pe_mac_sys.sv
// Self-checking bench for pe_mac_sys (DATA_W=16, ACC_W=32).
// A transaction-level model (queue of issued beats, plain integer arithmetic)
// predicts the outputs every cycle; directed steps add literal expectations.

module tb_pe_mac_sys;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 32;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clr_i  = 1'b0;
    logic          we_i   = 1'b0;
    logic          mode_i = 1'b0;
    logic          wload_i = 1'b0;
    logic [DW-1:0] srca_i = '0;
    logic [DW-1:0] srcb_i = '0;
    logic [AW-1:0] psum_i = '0;
    logic [DW-1:0] srca_o;
    logic [DW-1:0] srcb_o;
    logic          fwd_vld_o;
    logic [AW-1:0] psum_o;
    logic          valid_o;
`ifdef PE_SAT_EN
    logic          ovf_o;
`endif

    pe_mac_sys #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (clr_i),
        .we_i      (we_i),
        .mode_i    (mode_i),
        .wload_i   (wload_i),
        .srca_i    (srca_i),
        .srcb_i    (srcb_i),
        .psum_i    (psum_i),
        .srca_o    (srca_o),
        .srcb_o    (srcb_o),
        .fwd_vld_o (fwd_vld_o),
        .psum_o    (psum_o),
        .valid_o   (valid_o)
`ifdef PE_SAT_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint prod;
        bit     ws;
        longint psum;
    } beat_t;

    beat_t   pend[$];
    longint  m_acc = 0;
    longint  m_out = 0;
    longint  m_w   = 0;
    bit      m_last_ws = 1'b0;
    bit      m_valid = 1'b0;
    bit      m_fv = 1'b0;
    bit      m_ovf = 1'b0;
    logic [DW-1:0] m_fa = '0;
    logic [DW-1:0] m_fb = '0;

    // Reduce an exact sum to the ACC_W result (wrap or clamp)
    function automatic longint fold(input longint s, output bit hit);
        logic [31:0] t;
        hit = 1'b0;
`ifdef PE_SAT_EN
        if (s > 64'sd2147483647) begin
            hit = 1'b1;
            return 64'sd2147483647;
        end
        if (s < -64'sd2147483648) begin
            hit = 1'b1;
            return -64'sd2147483648;
        end
        return s;
`else
        t = s[31:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic logic [AW-1:0] exp_psum();
        longint v;
        v = m_last_ws ? m_out : m_acc;
        return v[AW-1:0];
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend.delete();
            m_acc = 0; m_out = 0; m_w = 0;
            m_last_ws = 1'b0; m_valid = 1'b0; m_fv = 1'b0; m_ovf = 1'b0;
            m_fa = '0; m_fb = '0;
        end else begin
            beat_t  b;
            bit     hit;
            longint base;
            base = clr_i ? 0 : m_acc;
            if (clr_i) m_ovf = 1'b0;
            m_valid = 1'b0;
            if (pend.size() > 0) begin
                b = pend.pop_front();
                m_valid = 1'b1;
                m_last_ws = b.ws;
                if (b.ws) m_out = fold(b.psum + b.prod, hit);
                else      base  = fold(base + b.prod, hit);
                if (hit) m_ovf = 1'b1;
            end
            m_acc = base;
            if (we_i) begin
                b.ws   = mode_i;
                b.prod = longint'($signed(srca_i)) *
                         (mode_i ? m_w : longint'($signed(srcb_i)));
                b.psum = longint'($signed(psum_i));
                pend.push_back(b);
            end
            if (wload_i) m_w = longint'($signed(srcb_i));
            m_fv = we_i | wload_i;
            if (m_fv) begin
                m_fa = srca_i;
                m_fb = srcb_i;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("valid_o", 64'(valid_o), 64'(m_valid));
            chk("psum_o", 64'(psum_o), 64'(exp_psum()));
            chk("fwd_vld_o", 64'(fwd_vld_o), 64'(m_fv));
            if (m_fv) begin
                chk("srca_o", 64'(srca_o), 64'(m_fa));
                chk("srcb_o", 64'(srcb_o), 64'(m_fb));
            end
`ifdef PE_SAT_EN
            chk("ovf_o", 64'(ovf_o), 64'(m_ovf));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit we, input bit mode, input bit wl, input bit clr,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [AW-1:0] ps);
        we_i = we; mode_i = mode; wload_i = wl; clr_i = clr;
        srca_i = a; srcb_i = b; psum_i = ps;
        @(negedge clk_i);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psum_o"}, 64'(psum_o), 64'd0);
        chk({tag, "_valid_o"}, 64'(valid_o), 64'd0);
        chk({tag, "_fwd_vld_o"}, 64'(fwd_vld_o), 64'd0);
        chk({tag, "_srca_o"}, 64'(srca_o), 64'd0);
        chk({tag, "_srcb_o"}, 64'(srcb_o), 64'd0);
`ifdef PE_SAT_EN
        chk({tag, "_ovf_o"}, 64'(ovf_o), 64'd0);
`endif
    endtask

    initial begin
        #12;
        chk_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();

        // OS accumulate: 10*2 + 9*0 = 0x14
        step(0, 0, 0, 1, '0, '0, '0);
        step(1, 0, 0, 0, 16'h000A, 16'h0002, '0);
        chk("os_first_valid", 64'(valid_o), 64'd0);
        step(1, 0, 0, 0, 16'h0009, 16'h0000, '0);
        chk("os_beat1_valid", 64'(valid_o), 64'd1);
        chk("os_beat1_psum", 64'(psum_o), 64'h14);
        idle();
        chk("os_beat2_valid", 64'(valid_o), 64'd1);
        chk("os_beat2_psum", 64'(psum_o), 64'h14);
        idle();
        chk("os_idle_valid", 64'(valid_o), 64'd0);
        chk("os_hold_psum", 64'(psum_o), 64'h14);

        // WS: w=3, a=5, psum_i=10 -> 25; accumulator untouched afterwards
        step(0, 0, 1, 0, '0, 16'h0003, '0);
        step(1, 1, 0, 0, 16'h0005, '0, 32'h0000000A);
        idle();
        chk("ws_psum", 64'(psum_o), 64'h19);
        step(1, 0, 0, 0, 16'h0001, 16'h0001, '0);
        idle();
        chk("ws_acc_kept", 64'(psum_o), 64'h15);

        // Signed product and forwarding
        step(0, 0, 0, 1, '0, '0, '0);
        step(1, 0, 0, 0, 16'hFFFD, 16'h0004, '0);
        chk("fwd_vld", 64'(fwd_vld_o), 64'd1);
        chk("fwd_srca", 64'(srca_o), 64'hFFFD);
        chk("fwd_srcb", 64'(srcb_o), 64'h0004);
        idle();
        chk("signed_psum", 64'(psum_o), 64'hFFFFFFF4);
        chk("fwd_drop", 64'(fwd_vld_o), 64'd0);

        // Overflow: three beats of 0x7FFF*0x7FFF
        step(0, 0, 0, 1, '0, '0, '0);
        repeat (3) step(1, 0, 0, 0, 16'h7FFF, 16'h7FFF, '0);
        idle();
`ifdef PE_SAT_EN
        chk("ovf_psum", 64'(psum_o), 64'h7FFFFFFF);
        chk("ovf_flag", 64'(ovf_o), 64'd1);
`else
        chk("wrap_psum", 64'(psum_o), 64'hBFFD0003);
`endif

        // clr_i coinciding with a stage-2 add of 0x14
        step(1, 0, 0, 0, 16'h000A, 16'h0002, '0);
        step(0, 0, 0, 1, '0, '0, '0);
        chk("clr_add_psum", 64'(psum_o), 64'h14);
`ifdef PE_SAT_EN
        chk("clr_ovf", 64'(ovf_o), 64'd0);
`endif

        // wload with WS beat uses old weight 3, new weight 7 afterwards
        step(0, 0, 1, 0, '0, 16'h0003, '0);
        step(1, 1, 1, 0, 16'h0002, 16'h0007, 32'h00000100);
        idle();
        chk("wload_old_w", 64'(psum_o), 64'h106);
        step(1, 1, 0, 0, 16'h0001, '0, '0);
        idle();
        chk("wload_new_w", 64'(psum_o), 64'h7);

        // Reset with beats in flight
        step(1, 0, 0, 0, 16'h0001, 16'h0001, '0);
        we_i = 1'b1; srca_i = 16'h0002; srcb_i = 16'h0002;
        #1 rst_ni = 1'b0;
        #1 chk_all_zero("midreset");
        we_i = 1'b0; srca_i = '0; srcb_i = '0;
        repeat (2) @(negedge clk_i);
        chk_all_zero("held_reset");
        rst_ni = 1'b1;
        repeat (3) begin
            idle();
            chk("post_reset_valid", 64'(valid_o), 64'd0);
            chk("post_reset_psum", 64'(psum_o), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
